// File: rtl/data_ram.sv
// data_ram: single-port data memory for the MIPS datapath.
//   Request/ready handshake, per-byte write enables, one-cycle registered read.
//   After reset the FSM walks every word and writes 0 (CLEAR), then serves
//   requests (IDLE). Misaligned or out-of-range accesses return an err pulse.
// Ports:
//   clock, reset_n         clock / async active-low reset
//   req, we, address,      request (accepted when req && ready)
//   writedata, be
//   ready                  high in IDLE
//   rvalid, out            read data, valid for one cycle after the accept edge
//   err                    one-cycle pulse for a rejected access

// One byte lane: its own storage array plus the registered read byte.
module data_ram_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX   = 10
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           wen,
  input  logic           ren,
  input  logic [IDX-1:0] idx,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata
);
  // Storage is not reset; the CLEAR walk zeroes it.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (wen) mem[idx] <= wdata;

  // Read byte holds until the next good read.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)  rdata <= 8'h00;
    else if (ren)  rdata <= mem[idx];
endmodule

module data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   out,
  output logic                err
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
  } mreq_t;

  state_t         state, state_nxt;
  logic [IDX-1:0] cnt;
  logic           clr;
  mreq_t          rq;
  logic           acc, misal, oor, bad;
  logic           good_rd, good_wr, bad_acc;
  logic [IDX-1:0] widx;
  logic [NB-1:0][7:0] rd_lane;

  assign rq = '{we: we, addr: address, wdata: writedata, be: be};

  // ---- FSM: state register ----
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    // Leave CLEAR on the edge that writes the last word.
    if (state == CLEAR && cnt == IDX'(DEPTH - 1)) state_nxt = IDLE;
  end

  // ---- FSM: outputs ----
  always_comb begin
    ready = 1'b0;
    clr   = 1'b0;
    case (state)
      CLEAR:   clr   = 1'b1;
      IDLE:    ready = 1'b1;
      default: ;
    endcase
  end

  // ---- address decode ----
  generate
    if (OFF > 0) begin : g_mis
      assign misal = |rq.addr[OFF-1:0];
    end else begin : g_nomis
      assign misal = 1'b0;
    end
    if (ADDR_W > OFF + IDX) begin : g_oor
      assign oor = |rq.addr[ADDR_W-1:OFF+IDX];
    end else begin : g_nooor
      assign oor = 1'b0;
    end
  endgenerate

  assign widx    = rq.addr[OFF+IDX-1:OFF];
  assign bad     = misal | oor;
  assign acc     = req & ready;
  assign good_rd = acc & ~bad & ~rq.we;
  assign good_wr = acc & ~bad &  rq.we;
  assign bad_acc = acc & bad;

  // ---- byte lanes ----
  // Accesses only happen in IDLE, so the CLEAR walk owns the lanes outright.
  generate
    for (genvar l = 0; l < NB; l++) begin : g_lane
      data_ram_lane #(.DEPTH(DEPTH), .IDX(IDX)) u_lane (
        .clock  (clock),
        .reset_n(reset_n),
        .wen    (clr | (good_wr & rq.be[l])),
        .ren    (good_rd),
        .idx    (clr ? cnt : widx),
        .wdata  (clr ? 8'h00 : rq.wdata[8*l +: 8]),
        .rdata  (rd_lane[l])
      );
    end
  endgenerate

  assign out = rd_lane;

  // ---- response pulses ----
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= good_rd;
      err    <= bad_acc;
    end
endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic        clock, reset_n, req, we;
  logic [31:0] address, writedata;
  logic [3:0]  be;
  logic        ready, rvalid, err;
  logic [31:0] out;

  data_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .address(address),
    .writedata(writedata), .be(be), .ready(ready), .rvalid(rvalid),
    .out(out), .err(err)
  );

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  sb_t         q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && (rvalid || err)) begin
      checks++;
      assert (!(rvalid && err)) else begin
        fails++; $error("FAIL both_pulses rvalid=%0b err=%0b expected not both", rvalid, err);
      end
      checks++;
      assert (q.size() != 0) else begin
        fails++; $error("FAIL unexpected_pulse rvalid=%0b err=%0b cyc=%0d expected no pulse", rvalid, err, cyc);
      end
      if (q.size() != 0) begin
        sb_t e;
        e = q.pop_front();
        checks++;
        assert (err === e.is_err && rvalid === !e.is_err) else begin
          fails++; $error("FAIL kind err=%0b rvalid=%0b expected err=%0b", err, rvalid, e.is_err);
        end
        checks++;
        assert (out === e.data) else begin
          fails++; $error("FAIL data out=%h expected %h", out, e.data);
        end
        checks++;
        assert (cyc === e.cyc) else begin
          fails++; $error("FAIL latency cyc=%0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  // One access; expectation is pushed as it is driven.
  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    sb_t e;
    logic badacc;
    badacc = (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
    if (badacc) begin
      e.is_err = 1'b1; e.data = last_rd; e.cyc = cyc + 1; q.push_back(e);
    end else if (w) begin
      for (int l = 0; l < 4; l++)
        if (b[l]) model[a[5:2]][8*l +: 8] = d[8*l +: 8];
    end else begin
      last_rd = model[a[5:2]];
      e.is_err = 1'b0; e.data = last_rd; e.cyc = cyc + 1; q.push_back(e);
    end
    req = 1'b1; we = w; address = a; writedata = d; be = b;
    @(posedge clock); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_q_empty(input string tag);
    checks++;
    assert (q.size() == 0) else begin
      fails++; $error("FAIL %s pending=%0d expected 0", tag, q.size());
    end
  endtask

  // Enter reset from #1 after an edge, check reset values, release mid-cycle.
  task automatic do_reset();
    reset_n = 1'b0;
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #2;
    checks++;
    assert (ready === 1'b0 && rvalid === 1'b0 && err === 1'b0 && out === 32'h0) else begin
      fails++; $error("FAIL reset_vals ready=%0b rvalid=%0b err=%0b out=%h expected 0/0/0/0", ready, rvalid, err, out);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clock); #1;   // edge 1 after release
  endtask

  // Check ready across n clear edges; edge 1 already consumed by do_reset.
  task automatic clear_chk(input int n);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clock); #1;
      end
      checks++;
      assert (ready === (k == DEPTH)) else begin
        fails++; $error("FAIL clear_ready edge=%0d ready=%0b expected %0b", k, ready, (k == DEPTH));
      end
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) acc(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle(2);
    check_q_empty("read_all");
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; address = '0; writedata = '0; be = '0;
    last_rd = '0;
    #12;
    // Handshake gating: hold a write request through the whole clear phase.
    req = 1'b1; we = 1'b1; address = 32'h0; writedata = 32'h12345678; be = 4'hF;
    do_reset();
    req = 1'b1;
    clear_chk(DEPTH);
    req = 1'b0;
    read_all_zero();

    // Dirty memory, then reset mid-run; clear must zero it again.
    for (int i = 0; i < DEPTH; i++) acc(1'b1, 32'(i * 4), 32'hA5A50000 + 32'(i), 4'hF);
    acc(1'b0, 32'h14, 32'h0, 4'h0);
    idle(2);
    check_q_empty("dirty");
    do_reset();
    clear_chk(5);
    // Reset mid-clear: restart must take the full DEPTH edges again.
    do_reset();
    clear_chk(DEPTH);
    read_all_zero();

    // Byte-enable merge, then be=0 no-op.
    acc(1'b1, 32'h08, 32'hAABBCCDD, 4'hF);
    acc(1'b1, 32'h08, 32'h11223344, 4'b0101);
    acc(1'b0, 32'h08, 32'h0, 4'h0);
    acc(1'b1, 32'h08, 32'h99999999, 4'h0);
    acc(1'b0, 32'h08, 32'h0, 4'h0);

    // Back-to-back write then read of the same word.
    acc(1'b1, 32'h3C, 32'hDEADBEEF, 4'hF);
    acc(1'b0, 32'h3C, 32'h0, 4'h0);

    // Errors, each followed by a read of 0x04.
    acc(1'b1, 32'h04, 32'h0BADF00D, 4'hF);
    acc(1'b0, 32'h04, 32'h0, 4'h0);
    acc(1'b1, 32'h05, 32'hFFFFFFFF, 4'hF);
    acc(1'b0, 32'h04, 32'h0, 4'h0);
    acc(1'b0, 32'h40, 32'h0, 4'h0);
    acc(1'b0, 32'h04, 32'h0, 4'h0);
    acc(1'b1, 32'h80000004, 32'h77777777, 4'hF);
    acc(1'b0, 32'h80000000, 32'h0, 4'h0);
    acc(1'b0, 32'h04, 32'h0, 4'h0);
    acc(1'b0, 32'h3C, 32'h0, 4'h0);
    idle(3);
    check_q_empty("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory for the MIPS datapath. It has a request/ready handshake, per-byte write enables, and one-cycle registered read latency. After reset it hardware-clears its contents, then flags bad accesses: misaligned addresses and addresses beyond the configured depth. It sits between the CPU load/store stage and the memory array, replacing the fixed-size, unclocked-read RAM.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, at least 8
- DEPTH, 1024, words stored; power of two, at least 2
- ADDR_W, 32, byte-address width; must satisfy ADDR_W >= log2(DEPTH) + log2(DATA_W/8)
- clock  input  1  single clock; all state changes on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  1  access request, qualified by ready
- we  input  1  1 = write, 0 = read; sampled with req
- address  input  ADDR_W  byte address
- writedata  input  DATA_W  write data
- be  input  DATA_W/8  byte-lane write enables; bit i covers writedata[8i+7:8i]
- ready  output  1  block accepts a request this cycle
- rvalid  output  1  one-cycle pulse; out holds read data
- out  output  DATA_W  read data
- err  output  1  one-cycle pulse; the accepted access was rejected

## Operation
- Derived constants:
  - OFF = log2(DATA_W/8); with DATA_W=8, OFF = 0 and there is no alignment check.
  - IDX = log2(DEPTH).
  - Word index = address[OFF+IDX-1:OFF].
- Accept: a request is accepted on the rising edge where req && ready. In all other cases, req, we, address, writedata and be are ignored.
- Bad access: address[OFF-1:0] != 0 (misaligned), or any bit of address[ADDR_W-1:OFF+IDX] is set (out of range).
  - Memory is not modified.
  - err = 1 on the next cycle.
  - rvalid = 0.
  - out is unchanged.
- Good write: each lane i with be[i] = 1 is updated from writedata; other lanes are kept. be = 0 is a legal no-op. rvalid and err stay 0.
- Good read: on the next cycle, rvalid = 1 and out = the stored word. out holds that value until the next good read.
- FSM states:
  - CLEAR: a counter walks word 0..DEPTH-1, writing 0 to each word; ready = 0.
  - IDLE: ready = 1.
- Transitions:
  - Any reset assertion forces CLEAR with the counter at 0.
  - CLEAR moves to IDLE on the edge that writes word DEPTH-1.
  - IDLE has no exit except reset.
- Reset during CLEAR or IDLE aborts everything; clearing restarts from word 0. Memory contents are not directly reset; they are zeroed by the CLEAR walk.
- Requests are not queued; a req held while ready = 0 has no effect.

## Timing
- Reset values while reset_n = 0: ready=0, rvalid=0, err=0, out=0, state=CLEAR, counter=0.
- Clear phase:
  - Edges 1..DEPTH after reset release write words 0..DEPTH-1.
  - ready rises after edge DEPTH.
  - The first request can be accepted on edge DEPTH+1.
- Read latency is 1 cycle: accepted on edge n, rvalid/out valid after edge n, sampled by the CPU on edge n+1.
- Write latency: memory is updated on the accepting edge.
  - A read of the same word accepted on the next edge returns the new data.
  - Back-to-back accesses are allowed every cycle (full throughput).
- rvalid and err are never both 1, and each stays high for exactly one cycle per accepted access.
- Fully synchronous read path: out changes only on clock edges, never combinationally from address.

## Test plan
Bench uses DATA_W=32, DEPTH=16, ADDR_W=32.
- Reset/clear: drop reset_n mid-run, release it -> ready=0 for exactly 16 edges, then 1. Reads of addresses 0x00..0x3C each return out=0x00000000 with rvalid one cycle later.
- Byte-enable write: write 0xAABBCCDD with be=4'hF to 0x08, then write 0x11223344 with be=4'b0101 -> read 0x08 gives out=0xAA22CC44.
- Back-to-back: write 0xDEADBEEF to 0x3C on edge n, read 0x3C on edge n+1 -> rvalid=1 with out=0xDEADBEEF after edge n+1; no idle cycles required.
- Errors, each followed by a read of 0x04 that still returns the previously written value:
  - Write to 0x05 -> err pulse, memory unchanged.
  - Read 0x40 -> err pulse, rvalid=0, out unchanged.
- Reset mid-clear: assert reset_n=0 after 5 clear edges, then release -> ready=0 for 16 full edges again.
- Handshake gating: req=1 with a write of 0x12345678 to 0x00 during CLEAR -> no effect; after ready rises, read 0x00 returns 0x00000000.
